// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage: bus widths, MIPS opcode/funct
// constants, ALU operation encodings and the ID/EX payload record.
package id_stage_pkg;

  localparam int REG_W   = 32;
  localparam int ADDR_W  = 5;
  localparam int ALUOP_W = 4;

  localparam logic [REG_W-1:0]  ZeroWord = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] ZeroAddr = 5'd0;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_NOP  = 4'h0,
    ALU_ADDU = 4'h1,
    ALU_SUBU = 4'h2,
    ALU_AND  = 4'h3,
    ALU_OR   = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_NOR  = 4'h6,
    ALU_SLT  = 4'h7,
    ALU_SLL  = 4'h8,
    ALU_SRL  = 4'h9,
    ALU_SRA  = 4'hA
  } aluop_e;

  typedef enum logic [1:0] {
    OPND2_REG  = 2'd0,
    OPND2_SEXT = 2'd1,
    OPND2_ZEXT = 2'd2,
    OPND2_LUI  = 2'd3
  } opnd2_sel_e;

  typedef struct packed {
    logic              valid;
    aluop_e            aluop;
    logic [REG_W-1:0]  opnd1;
    logic [REG_W-1:0]  opnd2;
    logic              wreg;
    logic [ADDR_W-1:0] wd;
    logic              is_load;
    logic              is_store;
    logic [REG_W-1:0]  store_data;
    logic [REG_W-1:0]  pc;
    logic              illegal;
  } id_ex_t;

  function automatic id_ex_t id_ex_bubble();
    id_ex_t b;
    b.valid      = 1'b0;
    b.aluop      = ALU_NOP;
    b.opnd1      = ZeroWord;
    b.opnd2      = ZeroWord;
    b.wreg       = 1'b0;
    b.wd         = ZeroAddr;
    b.is_load    = 1'b0;
    b.is_store   = 1'b0;
    b.store_data = ZeroWord;
    b.pc         = ZeroWord;
    b.illegal    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/id_fwd.sv
// Per-operand bypass mux: picks the youngest in-flight result for a register
// read, falling back to the register file.
module id_fwd
  import id_stage_pkg::*;
(
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [REG_W-1:0]  rdata,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [REG_W-1:0]  ex_wdata,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [REG_W-1:0]  mem_wdata,
  output logic [REG_W-1:0]  opnd
);

  // r0 is hardwired, so writes aimed at it never bypass; EX is younger than MEM
  always_comb begin
    if (!re) begin
      opnd = ZeroWord;
    end else if (raddr == ZeroAddr) begin
      opnd = rdata;
    end else if (ex_we && (ex_waddr == raddr)) begin
      opnd = ex_wdata;
    end else if (mem_we && (mem_waddr == raddr)) begin
      opnd = mem_wdata;
    end else begin
      opnd = rdata;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: decodes the fetched word, resolves operands with
// EX/MEM bypassing, detects load-use hazards and registers the ID/EX payload.
module id_stage
  import id_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [REG_W-1:0]  if_pc,
  input  logic [REG_W-1:0]  if_inst,
  output logic              re1,
  output logic              re2,
  output logic [ADDR_W-1:0] raddr1,
  output logic [ADDR_W-1:0] raddr2,
  input  logic [REG_W-1:0]  rdata1,
  input  logic [REG_W-1:0]  rdata2,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [REG_W-1:0]  ex_wdata,
  input  logic              ex_is_load,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [REG_W-1:0]  mem_wdata,
  input  logic              stall_i,
  input  logic              flush,
  output logic              stall_req,
  output logic              id_valid,
  output logic [ALUOP_W-1:0] id_aluop,
  output logic [REG_W-1:0]  id_opnd1,
  output logic [REG_W-1:0]  id_opnd2,
  output logic              id_wreg,
  output logic [ADDR_W-1:0] id_wd,
  output logic              id_is_load,
  output logic              id_is_store,
  output logic [REG_W-1:0]  id_store_data,
  output logic [REG_W-1:0]  id_pc,
  output logic              id_illegal
);

  logic [5:0]        op_s, funct_s;
  logic [ADDR_W-1:0] rs_s, rt_s, rd_s, shamt_s;
  logic [15:0]       imm_s;
  logic              dec_re1_s, dec_re2_s, shamt_sel_s;
  opnd2_sel_e        opnd2_sel_s;
  aluop_e            aluop_s;
  logic              wreg_s, is_load_s, is_store_s, illegal_s;
  logic [ADDR_W-1:0] wd_s;
  logic [REG_W-1:0]  fwd1_s, fwd2_s, opnd1_s, opnd2_s;
  logic              load_use_s;
  id_ex_t            next_s;
  id_ex_t            id_ex_r;

  assign op_s    = if_inst[31:26];
  assign rs_s    = if_inst[25:21];
  assign rt_s    = if_inst[20:16];
  assign rd_s    = if_inst[15:11];
  assign shamt_s = if_inst[10:6];
  assign funct_s = if_inst[5:0];
  assign imm_s   = if_inst[15:0];

  // Instruction decode into read enables, operand selection and payload controls
  always_comb begin
    dec_re1_s   = 1'b0;
    dec_re2_s   = 1'b0;
    shamt_sel_s = 1'b0;
    opnd2_sel_s = OPND2_REG;
    aluop_s     = ALU_NOP;
    wreg_s      = 1'b0;
    wd_s        = ZeroAddr;
    is_load_s   = 1'b0;
    is_store_s  = 1'b0;
    illegal_s   = 1'b0;
    case (op_s)
      OP_SPECIAL: begin
        dec_re1_s = 1'b1;
        dec_re2_s = 1'b1;
        wreg_s    = 1'b1;
        wd_s      = rd_s;
        case (funct_s)
          FN_ADDU: aluop_s = ALU_ADDU;
          FN_SUBU: aluop_s = ALU_SUBU;
          FN_AND:  aluop_s = ALU_AND;
          FN_OR:   aluop_s = ALU_OR;
          FN_XOR:  aluop_s = ALU_XOR;
          FN_NOR:  aluop_s = ALU_NOR;
          FN_SLT:  aluop_s = ALU_SLT;
          FN_SLL:  begin aluop_s = ALU_SLL; dec_re1_s = 1'b0; shamt_sel_s = 1'b1; end
          FN_SRL:  begin aluop_s = ALU_SRL; dec_re1_s = 1'b0; shamt_sel_s = 1'b1; end
          FN_SRA:  begin aluop_s = ALU_SRA; dec_re1_s = 1'b0; shamt_sel_s = 1'b1; end
          default: begin
            dec_re1_s = 1'b0;
            dec_re2_s = 1'b0;
            wreg_s    = 1'b0;
            wd_s      = ZeroAddr;
            illegal_s = 1'b1;
          end
        endcase
      end
      OP_ADDIU: begin aluop_s = ALU_ADDU; dec_re1_s = 1'b1; wreg_s = 1'b1; wd_s = rt_s; opnd2_sel_s = OPND2_SEXT; end
      OP_ANDI:  begin aluop_s = ALU_AND;  dec_re1_s = 1'b1; wreg_s = 1'b1; wd_s = rt_s; opnd2_sel_s = OPND2_ZEXT; end
      OP_ORI:   begin aluop_s = ALU_OR;   dec_re1_s = 1'b1; wreg_s = 1'b1; wd_s = rt_s; opnd2_sel_s = OPND2_ZEXT; end
      OP_XORI:  begin aluop_s = ALU_XOR;  dec_re1_s = 1'b1; wreg_s = 1'b1; wd_s = rt_s; opnd2_sel_s = OPND2_ZEXT; end
      OP_LUI:   begin aluop_s = ALU_OR;   wreg_s = 1'b1; wd_s = rt_s; opnd2_sel_s = OPND2_LUI; end
      OP_LW: begin
        aluop_s = ALU_ADDU; dec_re1_s = 1'b1; wreg_s = 1'b1; wd_s = rt_s;
        opnd2_sel_s = OPND2_SEXT; is_load_s = 1'b1;
      end
      OP_SW: begin
        aluop_s = ALU_ADDU; dec_re1_s = 1'b1; dec_re2_s = 1'b1;
        opnd2_sel_s = OPND2_SEXT; is_store_s = 1'b1;
      end
      default: illegal_s = 1'b1;
    endcase
  end

  assign re1    = dec_re1_s & if_valid & ~rst;
  assign re2    = dec_re2_s & if_valid & ~rst;
  assign raddr1 = if_valid ? rs_s : ZeroAddr;
  assign raddr2 = if_valid ? rt_s : ZeroAddr;

  id_fwd u_fwd1 (
    .re(re1), .raddr(raddr1), .rdata(rdata1),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .opnd(fwd1_s)
  );

  id_fwd u_fwd2 (
    .re(re2), .raddr(raddr2), .rdata(rdata2),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .opnd(fwd2_s)
  );

  // Load data only exists from MEM onward, so a load still in EX cannot be bypassed
  assign load_use_s = ex_is_load & ex_we & (ex_waddr != ZeroAddr) &
                      ((re1 & (ex_waddr == raddr1)) | (re2 & (ex_waddr == raddr2)));
  assign stall_req  = load_use_s & if_valid & ~rst;

  assign opnd1_s = shamt_sel_s ? {27'd0, shamt_s} : fwd1_s;

  // Second operand source: register, extended immediate or upper immediate
  always_comb begin
    case (opnd2_sel_s)
      OPND2_REG:  opnd2_s = fwd2_s;
      OPND2_SEXT: opnd2_s = {{16{imm_s[15]}}, imm_s};
      OPND2_ZEXT: opnd2_s = {16'h0000, imm_s};
      OPND2_LUI:  opnd2_s = {imm_s, 16'h0000};
      default:    opnd2_s = ZeroWord;
    endcase
  end

  // Assemble the payload to be registered for a normally advancing slot
  always_comb begin
    next_s            = id_ex_bubble();
    next_s.valid      = 1'b1;
    next_s.aluop      = aluop_s;
    next_s.opnd1      = opnd1_s;
    next_s.opnd2      = opnd2_s;
    next_s.wreg       = wreg_s;
    next_s.wd         = wd_s;
    next_s.is_load    = is_load_s;
    next_s.is_store   = is_store_s;
    next_s.store_data = is_store_s ? fwd2_s : ZeroWord;
    next_s.pc         = if_pc;
    next_s.illegal    = illegal_s;
  end

  // ID/EX register: flush beats downstream hold, which beats hazard bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_r <= id_ex_bubble();
    end else if (flush) begin
      id_ex_r <= id_ex_bubble();
    end else if (stall_i) begin
      id_ex_r <= id_ex_r;
    end else if (stall_req || !if_valid) begin
      id_ex_r <= id_ex_bubble();
    end else begin
      id_ex_r <= next_s;
    end
  end

  assign id_valid      = id_ex_r.valid;
  assign id_aluop      = id_ex_r.aluop;
  assign id_opnd1      = id_ex_r.opnd1;
  assign id_opnd2      = id_ex_r.opnd2;
  assign id_wreg       = id_ex_r.wreg;
  assign id_wd         = id_ex_r.wd;
  assign id_is_load    = id_ex_r.is_load;
  assign id_is_store   = id_ex_r.is_store;
  assign id_store_data = id_ex_r.store_data;
  assign id_pc         = id_ex_r.pc;
  assign id_illegal    = id_ex_r.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed, table-driven bench for id_stage with hand-computed expectations
// plus hand-written sequences for hazard, hold/flush and reset corners.
module tb_id_stage;

  logic        clk, rst, if_valid;
  logic [31:0] if_pc, if_inst;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        ex_we, ex_is_load, mem_we;
  logic [4:0]  ex_waddr, mem_waddr;
  logic [31:0] ex_wdata, mem_wdata;
  logic        stall_i, flush, stall_req;
  logic        id_valid, id_wreg, id_is_load, id_is_store, id_illegal;
  logic [3:0]  id_aluop;
  logic [31:0] id_opnd1, id_opnd2, id_store_data, id_pc;
  logic [4:0]  id_wd;

  int tests = 0;
  int fails = 0;

  id_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .stall_i(stall_i), .flush(flush), .stall_req(stall_req),
    .id_valid(id_valid), .id_aluop(id_aluop), .id_opnd1(id_opnd1), .id_opnd2(id_opnd2),
    .id_wreg(id_wreg), .id_wd(id_wd), .id_is_load(id_is_load), .id_is_store(id_is_store),
    .id_store_data(id_store_data), .id_pc(id_pc), .id_illegal(id_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [31:0] inst, pc, rd1, rd2;
    logic exwe; logic [4:0] exwa; logic [31:0] exwd; logic exld;
    logic mwe; logic [4:0] mwa; logic [31:0] mwd;
    logic re1, re2; logic [4:0] ra1, ra2; logic stl;
    logic ev; logic [3:0] aop; logic [31:0] o1, o2; logic wreg; logic [4:0] wd;
    logic ld, st; logic [31:0] sd; logic ill;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input logic ev, input logic [3:0] aop,
                          input logic [31:0] o1, input logic [31:0] o2, input logic wreg,
                          input logic [4:0] wd, input logic ld, input logic st,
                          input logic [31:0] sd, input logic [31:0] pc, input logic ill);
    chk({tag, " id_valid"}, 32'(id_valid), 32'(ev));
    chk({tag, " id_aluop"}, 32'(id_aluop), 32'(aop));
    chk({tag, " id_opnd1"}, id_opnd1, o1);
    chk({tag, " id_opnd2"}, id_opnd2, o2);
    chk({tag, " id_wreg"}, 32'(id_wreg), 32'(wreg));
    chk({tag, " id_wd"}, 32'(id_wd), 32'(wd));
    chk({tag, " id_is_load"}, 32'(id_is_load), 32'(ld));
    chk({tag, " id_is_store"}, 32'(id_is_store), 32'(st));
    chk({tag, " id_store_data"}, id_store_data, sd);
    chk({tag, " id_pc"}, id_pc, pc);
    chk({tag, " id_illegal"}, 32'(id_illegal), 32'(ill));
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic exwe, input logic [4:0] exwa, input logic [31:0] exwd,
                       input logic exld, input logic mwe, input logic [4:0] mwa,
                       input logic [31:0] mwd);
    if_valid = v; if_inst = inst; if_pc = pc; rdata1 = rd1; rdata2 = rd2;
    ex_we = exwe; ex_waddr = exwa; ex_wdata = exwd; ex_is_load = exld;
    mem_we = mwe; mem_waddr = mwa; mem_wdata = mwd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // v inst pc rd1 rd2 | exwe exwa exwd exld mwe mwa mwd | re1 re2 ra1 ra2 stl | ev aop o1 o2 wreg wd ld st sd ill
    vecs[0]  = '{1'b1, 32'h34018000, 32'h100, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 5'd0, 5'd1, 1'b0, 1'b1, 4'h4, 32'h0, 32'h8000, 1'b1, 5'd1, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 32'h00221821, 32'h104, 32'h11, 32'h22, 1'b1, 5'd1, 32'h5, 1'b0, 1'b1, 5'd1, 32'h9,
                 1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 4'h1, 32'h5, 32'h22, 1'b1, 5'd3, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[2]  = '{1'b1, 32'h00221821, 32'h108, 32'h11, 32'h22, 1'b1, 5'd7, 32'h77, 1'b0, 1'b1, 5'd2, 32'h9,
                 1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 4'h1, 32'h11, 32'h9, 1'b1, 5'd3, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 32'h2422FFFC, 32'h10C, 32'h100, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 1'b1, 4'h1, 32'h100, 32'hFFFFFFFC, 1'b1, 5'd2, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[4]  = '{1'b1, 32'h3022F0F0, 32'h110, 32'h100, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 1'b1, 4'h3, 32'h100, 32'h0000F0F0, 1'b1, 5'd2, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[5]  = '{1'b1, 32'h3C071234, 32'h114, 32'hDEAD, 32'hBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 5'd0, 5'd7, 1'b0, 1'b1, 4'h4, 32'h0, 32'h12340000, 1'b1, 5'd7, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[6]  = '{1'b1, 32'h000220C0, 32'h118, 32'hAAAA, 32'h40, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b1, 5'd0, 5'd2, 1'b0, 1'b1, 4'h8, 32'h3, 32'h40, 1'b1, 5'd4, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[7]  = '{1'b1, 32'h00022FC3, 32'h11C, 32'hAAAA, 32'h80000000, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b1, 5'd0, 5'd2, 1'b0, 1'b1, 4'hA, 32'h1F, 32'h80000000, 1'b1, 5'd5, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[8]  = '{1'b1, 32'h8FA40008, 32'h120, 32'h1000, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 5'd29, 5'd4, 1'b0, 1'b1, 4'h1, 32'h1000, 32'h8, 1'b1, 5'd4, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[9]  = '{1'b1, 32'hAFA5FFF8, 32'h124, 32'h1000, 32'h77, 1'b1, 5'd5, 32'h99, 1'b0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b1, 5'd29, 5'd5, 1'b0, 1'b1, 4'h1, 32'h1000, 32'hFFFFFFF8, 1'b0, 5'd0, 1'b0, 1'b1, 32'h99, 1'b0};
    vecs[10] = '{1'b1, 32'hFC000000, 32'h128, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1};
    vecs[11] = '{1'b1, 32'h00021821, 32'h12C, 32'h0, 32'h22, 1'b1, 5'd0, 32'hFFFF, 1'b0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b1, 5'd0, 5'd2, 1'b0, 1'b1, 4'h1, 32'h0, 32'h22, 1'b1, 5'd3, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[12] = '{1'b0, 32'h00221821, 32'h130, 32'h11, 32'h22, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[13] = '{1'b1, 32'h00221821, 32'h134, 32'h11, 32'h22, 1'b1, 5'd2, 32'h5, 1'b1, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[14] = '{1'b1, 32'h00223027, 32'h138, 32'h11, 32'h22, 1'b0, 5'd1, 32'h5, 1'b0, 1'b1, 5'd1, 32'h33,
                 1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 4'h6, 32'h33, 32'h22, 1'b1, 5'd6, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[15] = '{1'b1, 32'h0022382A, 32'h13C, 32'h11, 32'h22, 1'b1, 5'd0, 32'h5, 1'b1, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 4'h7, 32'h11, 32'h22, 1'b1, 5'd7, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[16] = '{1'b1, 32'h2422FFFC, 32'h140, 32'h11, 32'h22, 1'b1, 5'd2, 32'h5, 1'b1, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 1'b1, 4'h1, 32'h11, 32'hFFFFFFFC, 1'b1, 5'd2, 1'b0, 1'b0, 32'h0, 1'b0};

    // Reset with a live load-use hazard on the inputs
    rst = 1'b1; stall_i = 1'b0; flush = 1'b0;
    drive(1'b1, 32'h00842821, 32'h200, 32'h1, 32'h1, 1'b1, 5'd4, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
    step(); step();
    chk("rst re1", 32'(re1), 32'd0);
    chk("rst re2", 32'(re2), 32'd0);
    chk("rst stall_req", 32'(stall_req), 32'd0);
    chk_regs("rst", 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].v, vecs[i].inst, vecs[i].pc, vecs[i].rd1, vecs[i].rd2,
            vecs[i].exwe, vecs[i].exwa, vecs[i].exwd, vecs[i].exld,
            vecs[i].mwe, vecs[i].mwa, vecs[i].mwd);
      #1;
      chk($sformatf("v%0d re1", i), 32'(re1), 32'(vecs[i].re1));
      chk($sformatf("v%0d re2", i), 32'(re2), 32'(vecs[i].re2));
      chk($sformatf("v%0d raddr1", i), 32'(raddr1), 32'(vecs[i].ra1));
      chk($sformatf("v%0d raddr2", i), 32'(raddr2), 32'(vecs[i].ra2));
      chk($sformatf("v%0d stall_req", i), 32'(stall_req), 32'(vecs[i].stl));
      step();
      chk_regs($sformatf("v%0d", i), vecs[i].ev, vecs[i].aop, vecs[i].o1, vecs[i].o2,
               vecs[i].wreg, vecs[i].wd, vecs[i].ld, vecs[i].st, vecs[i].sd,
               vecs[i].ev ? vecs[i].pc : 32'h0, vecs[i].ill);
    end

    // Load-use: LW r4 in EX, ADDU r5,r4,r4 held in ID until the load reaches MEM
    drive(1'b1, 32'h00842821, 32'h300, 32'h1, 32'h1, 1'b1, 5'd4, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
    #1;
    chk("lu stall_req", 32'(stall_req), 32'd1);
    step();
    chk("lu bubble valid", 32'(id_valid), 32'd0);
    chk("lu bubble wreg", 32'(id_wreg), 32'd0);
    drive(1'b1, 32'h00842821, 32'h300, 32'h1, 32'h1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd4, 32'hCAFE);
    #1;
    chk("lu stall_req clear", 32'(stall_req), 32'd0);
    step();
    chk_regs("lu issue", 1'b1, 4'h1, 32'hCAFE, 32'hCAFE, 1'b1, 5'd5, 1'b0, 1'b0, 32'h0, 32'h300, 1'b0);

    // Downstream hold for three cycles, then flush while still held
    drive(1'b1, 32'h34018000, 32'h400, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    stall_i = 1'b1;
    drive(1'b1, 32'h00221821, 32'h404, 32'h11, 32'h22, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk_regs($sformatf("hold%0d", c), 1'b1, 4'h4, 32'h0, 32'h8000, 1'b1, 5'd1, 1'b0, 1'b0,
               32'h0, 32'h400, 1'b0);
    end
    flush = 1'b1;
    step();
    chk_regs("flush", 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    flush = 1'b0; stall_i = 1'b0;

    // Reset arriving in the middle of a load-use stall
    drive(1'b1, 32'h8FA40008, 32'h500, 32'h1000, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("pre-rst load", 32'(id_is_load), 32'd1);
    drive(1'b1, 32'h00842821, 32'h504, 32'h1, 32'h1, 1'b1, 5'd4, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
    #1;
    chk("pre-rst stall_req", 32'(stall_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid-rst stall_req", 32'(stall_req), 32'd0);
    chk("mid-rst re1", 32'(re1), 32'd0);
    step();
    chk_regs("mid-rst", 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
